// File: rtl/color_step_pwm.sv
// color_step_pwm: synchronises the divided step clock into ticks that step or fade an 8-colour palette,
// and drives three PWM LED outputs from the current colour.
module color_step_pwm #(
    parameter int FADE_STEP = 16,
    parameter int PWM_W     = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        step_clk,
    input  logic        en,
    input  logic        mode,
    output logic [2:0]  idx,
    output logic [23:0] color,
    output logic        pwm_r,
    output logic        pwm_g,
    output logic        pwm_b
);
    typedef enum logic [1:0] {IDLE, STEP, FADE} state_t;

    localparam logic [23:0] PAL [8] = '{
        24'hFF0000, 24'hFF8000, 24'hFFFF00, 24'h00FF00,
        24'h00FFFF, 24'h0000FF, 24'hFF00FF, 24'hFFFFFF
    };
    localparam logic [7:0] STEP8 = 8'(FADE_STEP);

    state_t             state;
    logic               s1, s2, s3, tick;
    logic [PWM_W-1:0]   pwm_cnt;
    logic [2:0]         idx_nxt;
    logic [23:0]        pal_cur, pal_nxt, ramped;

    // Move one channel toward its target by at most STEP8, never overshooting.
    function automatic logic [7:0] ramp_ch(input logic [7:0] c, input logic [7:0] t);
        return c < t ? (t - c > STEP8 ? c + STEP8 : t)
                     : (c - t > STEP8 ? c - STEP8 : t);
    endfunction

    assign tick    = s2 & ~s3;
    assign idx_nxt = idx + 3'd1;
    assign pal_cur = PAL[idx];
    assign pal_nxt = PAL[idx_nxt];
    assign ramped  = {ramp_ch(color[23:16], pal_cur[23:16]),
                      ramp_ch(color[15:8],  pal_cur[15:8]),
                      ramp_ch(color[7:0],   pal_cur[7:0])};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            {s1, s2, s3} <= 3'b000;
            state        <= IDLE;
            idx          <= 3'd0;
            color        <= 24'hFF0000;
            pwm_cnt      <= '0;
            {pwm_r, pwm_g, pwm_b} <= 3'b000;
        end else begin
            {s1, s2, s3} <= {step_clk, s1, s2};
            state        <= !en ? IDLE : mode ? FADE : STEP;
            pwm_cnt      <= pwm_cnt == PWM_W'(254) ? '0 : pwm_cnt + 1'b1;
            pwm_r        <= pwm_cnt < color[23:16];
            pwm_g        <= pwm_cnt < color[15:8];
            pwm_b        <= pwm_cnt < color[7:0];
            if (tick && state == STEP) begin
                idx   <= idx_nxt;
                color <= pal_nxt;
            end else if (tick && state == FADE) begin
                // A tick that finds the target already reached only advances the target.
                if (color == pal_cur)
                    idx <= idx_nxt;
                else
                    color <= ramped;
            end
        end
    end
endmodule

// File: tb/tb_color_step_pwm.sv
// tb_color_step_pwm: table vectors plus randomized ticks against a palette/fade reference model,
// run on two instances (FADE_STEP 16 and 100) sharing the same stimulus.
module tb_color_step_pwm;
    logic        clk = 0, rst = 1, step_clk = 0, en = 0, mode = 0;
    logic [2:0]  idx_a, idx_b;
    logic [23:0] col_a, col_b;
    logic        pr_a, pg_a, pb_a, pr_b, pg_b, pb_b;

    always #5 clk = ~clk;

    color_step_pwm #(.FADE_STEP(16), .PWM_W(8)) dut_a (
        .clk(clk), .rst(rst), .step_clk(step_clk), .en(en), .mode(mode),
        .idx(idx_a), .color(col_a), .pwm_r(pr_a), .pwm_g(pg_a), .pwm_b(pb_a));
    color_step_pwm #(.FADE_STEP(100), .PWM_W(8)) dut_b (
        .clk(clk), .rst(rst), .step_clk(step_clk), .en(en), .mode(mode),
        .idx(idx_b), .color(col_b), .pwm_r(pr_b), .pwm_g(pg_b), .pwm_b(pb_b));

    typedef struct {
        bit          r;
        bit          e;
        bit          m;
        bit          sel;
        logic [2:0]  i;
        logic [23:0] c;
    } vec_t;

    vec_t        tbl[$];
    int          checks = 0, errors = 0;
    logic [23:0] pal [8] = '{24'hFF0000, 24'hFF8000, 24'hFFFF00, 24'h00FF00,
                             24'h00FFFF, 24'h0000FF, 24'hFF00FF, 24'hFFFFFF};
    int          steps [2] = '{16, 100};
    int          m_idx [2];
    logic [23:0] m_col [2];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %h required %h", nm, act, exp);
        end
    endtask

    function automatic logic [23:0] fade(input logic [23:0] c, input logic [23:0] t, input int s);
        logic [23:0] r;
        for (int k = 0; k < 3; k++) begin
            int d;
            d = int'(t[k*8 +: 8]) - int'(c[k*8 +: 8]);
            if (d > s) d = s;
            if (d < -s) d = -s;
            r[k*8 +: 8] = 8'(int'(c[k*8 +: 8]) + d);
        end
        return r;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_idx[k] = 0;
            m_col[k] = 24'hFF0000;
        end
    endtask

    task automatic model_tick();
        for (int k = 0; k < 2; k++) begin
            if (!en) continue;
            if (!mode) begin
                m_idx[k] = (m_idx[k] + 1) % 8;
                m_col[k] = pal[m_idx[k]];
            end else if (m_col[k] == pal[m_idx[k]])
                m_idx[k] = (m_idx[k] + 1) % 8;
            else
                m_col[k] = fade(m_col[k], pal[m_idx[k]], steps[k]);
        end
    endtask

    // With a held colour, any 255-cycle window sees each counter value once.
    task automatic duty();
        int n[6];
        n = '{default: 0};
        repeat (255) begin
            @(negedge clk);
            n[0] += int'(pr_a); n[1] += int'(pg_a); n[2] += int'(pb_a);
            n[3] += int'(pr_b); n[4] += int'(pg_b); n[5] += int'(pb_b);
        end
        chk("duty_r16", n[0], m_col[0][23:16]);
        chk("duty_g16", n[1], m_col[0][15:8]);
        chk("duty_b16", n[2], m_col[0][7:0]);
        chk("duty_r100", n[3], m_col[1][23:16]);
        chk("duty_g100", n[4], m_col[1][15:8]);
        chk("duty_b100", n[5], m_col[1][7:0]);
    endtask

    task automatic check_all();
        chk("idx16", idx_a, m_idx[0]);
        chk("col16", col_a, m_col[0]);
        chk("idx100", idx_b, m_idx[1]);
        chk("col100", col_b, m_col[1]);
        duty();
    endtask

    task automatic pulse();
        @(negedge clk) step_clk = 1;
        repeat (4) @(negedge clk);
        step_clk = 0;
        repeat (4) @(negedge clk);
        model_tick();
        check_all();
    endtask

    task automatic do_reset();
        @(negedge clk);
        step_clk = 0;
        #2 rst = 1;
        #1;
        chk("rst_idx16", idx_a, 0);
        chk("rst_col16", col_a, 24'hFF0000);
        chk("rst_idx100", idx_b, 0);
        chk("rst_col100", col_b, 24'hFF0000);
        repeat (3) @(negedge clk);
        chk("rst_pwm", {pr_a, pg_a, pb_a, pr_b, pg_b, pb_b}, 0);
        rst = 0;
        model_reset();
        duty();
    endtask

    task automatic latency();
        logic [2:0] old;
        old = 3'(m_idx[0]);
        @(negedge clk) step_clk = 1;
        @(negedge clk);
        @(negedge clk);
        chk("lat_after_e1", idx_a, old);
        @(negedge clk);
        chk("lat_after_e2", idx_a, 3'(old + 3'd1));
        step_clk = 0;
        repeat (4) @(negedge clk);
        model_tick();
        check_all();
    endtask

    task automatic add(input bit r, input bit e, input bit m, input bit sel,
                       input logic [2:0] i, input logic [23:0] c);
        vec_t v;
        v.r = r; v.e = e; v.m = m; v.sel = sel; v.i = i; v.c = c;
        tbl.push_back(v);
    endtask

    task automatic run_table(input int lo, input int hi);
        for (int i = lo; i < hi; i++) begin
            if (tbl[i].r) do_reset();
            en   = tbl[i].e;
            mode = tbl[i].m;
            pulse();
            if (tbl[i].sel) begin
                chk($sformatf("vec%0d_idx100", i), idx_b, tbl[i].i);
                chk($sformatf("vec%0d_col100", i), col_b, tbl[i].c);
            end else begin
                chk($sformatf("vec%0d_idx16", i), idx_a, tbl[i].i);
                chk($sformatf("vec%0d_col16", i), col_a, tbl[i].c);
            end
        end
    endtask

    initial begin
        repeat (100000) @(posedge clk);
        $display("FAIL watchdog cycle budget exhausted");
        $fatal(1);
    end

    initial begin
        // STEP walk through the palette, wrapping 7 -> 0
        for (int s = 1; s <= 9; s++) add(0, 1, 0, 0, 3'(s % 8), pal[s % 8]);
        // FADE from index 0 with step 16, then freeze, then snap in STEP
        add(0, 1, 1, 0, 3'd1, 24'hFF0000);
        for (int g = 1; g <= 8; g++) add(0, 1, 1, 0, 3'd1, 24'hFF0000 | 24'(g * 16) << 8);
        add(0, 1, 1, 0, 3'd2, 24'hFF8000);
        add(0, 1, 1, 0, 3'd2, 24'hFF9000);
        repeat (5) add(0, 0, 1, 0, 3'd2, 24'hFF9000);
        add(0, 1, 0, 0, 3'd3, 24'h00FF00);
        // FADE clamping with step 100: FFFF00 -> 00FF00
        add(1, 1, 0, 1, 3'd1, 24'hFF8000);
        add(0, 1, 0, 1, 3'd2, 24'hFFFF00);
        add(0, 1, 1, 1, 3'd3, 24'hFFFF00);
        add(0, 1, 1, 1, 3'd3, 24'h9BFF00);
        add(0, 1, 1, 1, 3'd3, 24'h37FF00);
        add(0, 1, 1, 1, 3'd3, 24'h00FF00);
        add(0, 1, 1, 1, 3'd4, 24'h00FF00);

        model_reset();
        repeat (2) @(negedge clk);
        do_reset();
        run_table(0, 9);
        latency();
        mode = 1;
        pulse();
        pulse();
        do_reset();
        run_table(9, tbl.size());

        repeat (40) begin
            if ($urandom_range(9) == 0) do_reset();
            en   = $urandom_range(3) != 0;
            mode = 1'($urandom_range(1));
            pulse();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/color_step_pwm.md
Name: color_step_pwm

Overview:
Downstream consumer of the clock-divider output. It takes the divided square wave (step_clk) and synchronises it into the fast system clock domain. Each rising edge becomes a one-cycle tick. Ticks advance an 8-entry RGB colour palette, either by hard stepping or by gradual fade, and the current colour drives three PWM LED outputs.

Parameters:
FADE_STEP, 16, per-tick channel increment/decrement in fade mode (1..255)
PWM_W, 8, channel and PWM counter width (fixed at 8; palette defined for 8)

Ports:
clk  in  1  system clock (same clock that feeds the divider)
rst  in  1  asynchronous reset, active-high
step_clk  in  1  divided clock from the divider stage; asynchronous to this block's logic
en  in  1  1 = sequencing active; 0 = freeze colour and index
mode  in  1  0 = STEP (hard change), 1 = FADE (ramp toward next colour)
idx  out  3  palette index of current/target colour
color  out  24  current colour {R,G,B}, 8 bits each
pwm_r  out  1  red PWM output
pwm_g  out  1  green PWM output
pwm_b  out  1  blue PWM output

Behaviour:
- Palette (fixed ROM), indexed 0..7: FF0000, FF8000, FFFF00, 00FF00, 00FFFF, 0000FF, FF00FF, FFFFFF.
- Reset values: idx=0, color=FF0000, pwm_cnt=0, pwm_r/g/b=0, sync flops=0, state=IDLE.
- Tick generation:
  - Synchroniser chain s1→s2→s3, all reset to 0.
  - tick = s2 & ~s3.
  - If step_clk is first sampled high at edge E0, tick is high for exactly one cycle between E1 and E2.
  - State and colour updates triggered by the tick are visible after E2.
- Tick spacing and limits:
  - Consecutive ticks are at least 2 cycles apart. The divider guarantees a much larger spacing.
  - A step_clk pulse shorter than one clk period may be lost; this is acceptable.
- State register, updated every clk:
  - IDLE when en=0.
  - STEP when en=1 and mode=0.
  - FADE when en=1 and mode=1.
  - Transitions take effect on the next clk edge. Ticks are evaluated against the registered state.
- IDLE: ticks ignored; idx and color hold; PWM keeps running.
- STEP, on tick: idx <= idx+1 (7 wraps to 0); color <= palette[idx+1].
- FADE, meaning of idx: the target colour index.
- FADE, on tick, each channel c moves toward target t:
  - c < t: c <= c + min(FADE_STEP, t−c).
  - c > t: c <= c − min(FADE_STEP, c−t).
  - No overflow or underflow past the target.
- FADE, arrival: when, after a tick, all three channels equal palette[idx], the next tick performs no ramp. It sets idx <= idx+1 (wrap) only, and ramping toward the new target starts on the following tick.
- Entering FADE from STEP/IDLE: color already equals palette[idx], so the first tick only advances idx.
- Leaving FADE mid-ramp into STEP: the next tick sets idx <= idx+1 and color <= palette[idx+1]. The partial colour is discarded.
- Leaving FADE mid-ramp into IDLE: the partial colour is held.
- PWM:
  - pwm_cnt counts 0..254 and wraps to 0 (period 255 clk).
  - pwm_x <= (pwm_cnt < color_x), registered, so there is 1 cycle of latency from color to pwm.
  - Channel value 00 gives a constant 0; FF gives a constant 1.
  - A colour change mid-period takes effect on the next compare; no period restart.
- rst mid-operation: all state returns to reset values immediately. After release, the first tick requires a fresh rising edge of step_clk. The shared reset also holds the divider output low, so no spurious tick is produced.

Test Plan:
1. Reset: assert rst mid-fade → idx=0, color=FF0000, pwm all 0 during reset. After release, pwm_r=1 and pwm_g=pwm_b=0 continuously.
2. STEP: en=1, mode=0, apply 9 step_clk rising edges → idx sequence 1..7,0,1; color after the 3rd edge = 00FF00. Each update appears exactly 2 clk edges after step_clk is first sampled high.
3. FADE arithmetic: FADE_STEP=16, from idx 0, 1 tick advances idx to 1. Next 8 ticks give G = 10,20,...,80 and R stays FF. Further ticks hold 80; the following tick advances idx to 2.
4. Clamp: FADE_STEP=100, fade FFFF00→00FF00 → R = 9B, 37, 00. No wrap below 0.
5. Freeze and mode switch: en=0 for 5 ticks → idx and color unchanged, PWM still toggling. Switching mid-ramp to mode=0 → next tick snaps color to palette[idx+1].
6. PWM duty: color=804000 held for 255 cycles → pwm_r high 128 cycles, pwm_g high 64 cycles, pwm_b high 0 cycles.
